sweep_ctrl: RTL and testbench

Frequency sweep controller that produces the live `current_freq` word for the DDS phase accumulator and the debug probe bus. It applies one of four sweep modes between programmable bounds at a fixed step rate. In fixed mode it passes `freq_config` through. It sits directly upstream of the DDS core, and its outputs are also routed to the logic-analyzer probes.

---
 rtl/sweep_pkg.sv | 14 +
 rtl/step_prescaler.sv | 28 ++
 rtl/sweep_ctrl.sv | 127 ++++++++++++
 tb/tb_sweep_ctrl.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/sweep_pkg.sv
// Shared definitions for the frequency sweep controller: the sweep mode
// encoding and the default frequency word width.
package sweep_pkg;

  localparam int DEFAULT_FREQ_W = 20;

  typedef enum logic [1:0] {
    SWEEP_FIXED = 2'b00,
    SWEEP_UP    = 2'b01,
    SWEEP_DOWN  = 2'b10,
    SWEEP_TRI   = 2'b11
  } sweep_mode_e;

endpackage

// File: rtl/step_prescaler.sv
// Modulo-STEP_DIV counter that marks the terminal count on which a sweep step
// is taken; holds while disabled and clears on request.
module step_prescaler #(
  parameter int STEP_DIV = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CW = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(STEP_DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/sweep_ctrl.sv
// Frequency sweep controller feeding the DDS core: fixed, linear up/down and
// triangle sweeps between live bounds, one step every STEP_DIV cycles.
module sweep_ctrl
  import sweep_pkg::*;
#(
  parameter int FREQ_W   = DEFAULT_FREQ_W,
  parameter int STEP_DIV = 100000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [1:0]        sweep_mode,
  input  logic [FREQ_W-1:0] freq_config,
  input  logic [FREQ_W-1:0] freq_min,
  input  logic [FREQ_W-1:0] freq_max,
  input  logic [FREQ_W-1:0] freq_step,
  output logic [FREQ_W-1:0] current_freq,
  output logic              sweep_dir,
  output logic              step_tick,
  output logic              sweep_wrap,
  output logic              cfg_err
);

  sweep_mode_e mode_in, mode_q;
  logic        restart_q, restart, pre_tick;

  logic [FREQ_W-1:0] freq_d;
  logic              dir_d, tick_d, wrap_d;
  logic [FREQ_W:0]   cur_plus_step, min_plus_step;

  assign mode_in = sweep_mode_e'(sweep_mode);
  assign restart = restart_q || (mode_in != mode_q);

  // Extra bit on the sums so bound comparisons never overflow.
  assign cur_plus_step = {1'b0, current_freq} + {1'b0, freq_step};
  assign min_plus_step = {1'b0, freq_min} + {1'b0, freq_step};

  step_prescaler #(.STEP_DIV(STEP_DIV)) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .clr  (restart),
    .en   (enable),
    .tick (pre_tick)
  );

  always_comb begin
    freq_d = current_freq;
    dir_d  = sweep_dir;
    tick_d = 1'b0;
    wrap_d = 1'b0;
    if (restart) begin
      case (mode_in)
        SWEEP_FIXED: begin freq_d = freq_config; dir_d = 1'b0; end
        SWEEP_UP:    begin freq_d = freq_min;    dir_d = 1'b0; end
        SWEEP_DOWN:  begin freq_d = freq_max;    dir_d = 1'b1; end
        default:     begin freq_d = freq_min;    dir_d = 1'b0; end
      endcase
    end else if (mode_in == SWEEP_FIXED) begin
      if (enable) freq_d = freq_config;
      tick_d = pre_tick;
    end else if (cfg_err) begin
      // Inverted bounds: park on the lower bound until they are fixed.
      freq_d = freq_min;
    end else if (pre_tick) begin
      tick_d = 1'b1;
      if (freq_step != '0) begin
        case (mode_in)
          SWEEP_UP: begin
            if (cur_plus_step > {1'b0, freq_max}) begin
              freq_d = freq_min;
              wrap_d = 1'b1;
            end else begin
              freq_d = cur_plus_step[FREQ_W-1:0];
            end
          end
          SWEEP_DOWN: begin
            if ({1'b0, current_freq} < min_plus_step) begin
              freq_d = freq_max;
              wrap_d = 1'b1;
            end else begin
              freq_d = current_freq - freq_step;
            end
          end
          default: begin
            if (!sweep_dir) begin
              if (cur_plus_step >= {1'b0, freq_max}) begin
                freq_d = freq_max;
                dir_d  = 1'b1;
              end else begin
                freq_d = cur_plus_step[FREQ_W-1:0];
              end
            end else begin
              if ({1'b0, current_freq} <= min_plus_step) begin
                freq_d = freq_min;
                dir_d  = 1'b0;
                wrap_d = 1'b1;
              end else begin
                freq_d = current_freq - freq_step;
              end
            end
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      current_freq <= '0;
      sweep_dir    <= 1'b0;
      step_tick    <= 1'b0;
      sweep_wrap   <= 1'b0;
      cfg_err      <= 1'b0;
      restart_q    <= 1'b1;
      mode_q       <= SWEEP_FIXED;
    end else begin
      current_freq <= freq_d;
      sweep_dir    <= dir_d;
      step_tick    <= tick_d;
      sweep_wrap   <= wrap_d;
      cfg_err      <= (freq_min > freq_max);
      restart_q    <= 1'b0;
      mode_q       <= mode_in;
    end
  end

endmodule

// File: tb/tb_sweep_ctrl.sv
// Directed, table-driven bench for sweep_ctrl with STEP_DIV = 4; expected
// values are hand-computed from the sweep rules.
module tb_sweep_ctrl;

  localparam int FW = 20;

  typedef struct {
    int          cycles;
    logic        en;
    logic [1:0]  mode;
    logic [FW-1:0] fmin, fmax, fstep;
    logic [FW-1:0] exp_freq;
    logic        exp_dir, exp_tick, exp_wrap, exp_err;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst, enable;
  logic [1:0]    sweep_mode;
  logic [FW-1:0] freq_config, freq_min, freq_max, freq_step;
  logic [FW-1:0] current_freq;
  logic          sweep_dir, step_tick, sweep_wrap, cfg_err;

  int checks = 0;
  int passed = 0;
  vec_t vecs[$];

  sweep_ctrl #(.FREQ_W(FW), .STEP_DIV(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .sweep_mode   (sweep_mode),
    .freq_config  (freq_config),
    .freq_min     (freq_min),
    .freq_max     (freq_max),
    .freq_step    (freq_step),
    .current_freq (current_freq),
    .sweep_dir    (sweep_dir),
    .step_tick    (step_tick),
    .sweep_wrap   (sweep_wrap),
    .cfg_err      (cfg_err)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(int cyc, logic en, logic [1:0] mode,
                              int mn, int mx, int st, int f,
                              logic d, logic t, logic w, logic e);
    vec_t v;
    v.cycles = cyc; v.en = en; v.mode = mode;
    v.fmin = FW'(mn); v.fmax = FW'(mx); v.fstep = FW'(st);
    v.exp_freq = FW'(f);
    v.exp_dir = d; v.exp_tick = t; v.exp_wrap = w; v.exp_err = e;
    return v;
  endfunction

  task automatic tick_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input vec_t v);
    enable     = v.en;
    sweep_mode = v.mode;
    freq_min   = v.fmin;
    freq_max   = v.fmax;
    freq_step  = v.fstep;
    repeat (v.cycles) tick_clk();
  endtask

  task automatic checkOutput(input string name, input logic [FW-1:0] f,
                             input logic d, input logic t, input logic w,
                             input logic e);
    logic [FW+3:0] got, want;
    got  = {current_freq, sweep_dir, step_tick, sweep_wrap, cfg_err};
    want = {f, d, t, w, e};
    checks++;
    if (got === want) passed++;
    else
      $display("[TB] FAIL %s: got freq=%0d dir=%b tick=%b wrap=%b err=%b, expected freq=%0d dir=%b tick=%b wrap=%b err=%b",
               name, current_freq, sweep_dir, step_tick, sweep_wrap, cfg_err, f, d, t, w, e);
  endtask

  initial begin
    // Reset, then fixed mode passthrough
    rst = 1'b1; enable = 1'b1; sweep_mode = 2'b00;
    freq_config = FW'(1000); freq_min = '0; freq_max = '0; freq_step = '0;
    repeat (2) tick_clk();
    checkOutput("reset", 0, 0, 0, 0, 0);
    rst = 1'b0;
    tick_clk();
    checkOutput("fixed_load", 1000, 0, 0, 0, 0);
    for (int i = 2; i <= 9; i++) begin
      tick_clk();
      checkOutput($sformatf("fixed_cyc%0d", i), 1000, 0,
                  (i == 5 || i == 9), 0, 0);
    end

    // Up sweep with wrap
    vecs.push_back(mk(1, 1, 2'b01, 100, 400, 100, 100, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 2'b01, 100, 400, 100, 100, 0, 0, 0, 0));
    vecs.push_back(mk(3, 1, 2'b01, 100, 400, 100, 200, 0, 1, 0, 0));
    vecs.push_back(mk(4, 1, 2'b01, 100, 400, 100, 300, 0, 1, 0, 0));
    vecs.push_back(mk(4, 1, 2'b01, 100, 400, 100, 400, 0, 1, 0, 0));
    vecs.push_back(mk(4, 1, 2'b01, 100, 400, 100, 100, 0, 1, 1, 0));
    // Triangle
    vecs.push_back(mk(1, 1, 2'b11, 0, 250, 100,   0, 0, 0, 0, 0));
    vecs.push_back(mk(4, 1, 2'b11, 0, 250, 100, 100, 0, 1, 0, 0));
    vecs.push_back(mk(4, 1, 2'b11, 0, 250, 100, 200, 0, 1, 0, 0));
    vecs.push_back(mk(4, 1, 2'b11, 0, 250, 100, 250, 1, 1, 0, 0));
    vecs.push_back(mk(1, 1, 2'b11, 0, 250, 100, 250, 1, 0, 0, 0));
    vecs.push_back(mk(3, 1, 2'b11, 0, 250, 100, 150, 1, 1, 0, 0));
    vecs.push_back(mk(4, 1, 2'b11, 0, 250, 100,  50, 1, 1, 0, 0));
    vecs.push_back(mk(4, 1, 2'b11, 0, 250, 100,   0, 0, 1, 1, 0));
    vecs.push_back(mk(1, 1, 2'b11, 0, 250, 100,   0, 0, 0, 0, 0));
    vecs.push_back(mk(3, 1, 2'b11, 0, 250, 100, 100, 0, 1, 0, 0));
    // Down sweep, then switch to up on the terminal-count edge
    vecs.push_back(mk(1, 1, 2'b10, 10, 30, 10, 30, 1, 0, 0, 0));
    vecs.push_back(mk(4, 1, 2'b10, 10, 30, 10, 20, 1, 1, 0, 0));
    vecs.push_back(mk(4, 1, 2'b10, 10, 30, 10, 10, 1, 1, 0, 0));
    vecs.push_back(mk(4, 1, 2'b10, 10, 30, 10, 30, 1, 1, 1, 0));
    vecs.push_back(mk(3, 1, 2'b10, 10, 30, 10, 30, 1, 0, 0, 0));
    vecs.push_back(mk(1, 1, 2'b01, 10, 30, 10, 10, 0, 0, 0, 0));
    vecs.push_back(mk(4, 1, 2'b01, 10, 30, 10, 20, 0, 1, 0, 0));
    // Enable hold resumes with the remaining count
    vecs.push_back(mk(2, 1, 2'b01, 10, 30, 10, 20, 0, 0, 0, 0));
    vecs.push_back(mk(5, 0, 2'b01, 10, 30, 10, 20, 0, 0, 0, 0));
    vecs.push_back(mk(5, 0, 2'b01, 10, 30, 10, 20, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 2'b01, 10, 30, 10, 20, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 2'b01, 10, 30, 10, 30, 0, 1, 0, 0));
    // Zero step
    vecs.push_back(mk(4, 1, 2'b01, 10, 30, 0, 30, 0, 1, 0, 0));
    vecs.push_back(mk(4, 1, 2'b01, 10, 30, 0, 30, 0, 1, 0, 0));
    // Inverted bounds, then repaired
    vecs.push_back(mk(1, 1, 2'b01, 500, 200, 100,  30, 0, 0, 0, 1));
    vecs.push_back(mk(1, 1, 2'b01, 500, 200, 100, 500, 0, 0, 0, 1));
    vecs.push_back(mk(2, 1, 2'b01, 500, 200, 100, 500, 0, 0, 0, 1));
    vecs.push_back(mk(1, 1, 2'b01, 500, 800, 100, 500, 0, 0, 0, 0));
    vecs.push_back(mk(3, 1, 2'b01, 500, 800, 100, 600, 0, 1, 0, 0));
    vecs.push_back(mk(4, 1, 2'b01, 500, 800, 100, 700, 0, 1, 0, 0));
    vecs.push_back(mk(4, 1, 2'b01, 500, 800, 100, 800, 0, 1, 0, 0));
    vecs.push_back(mk(4, 1, 2'b01, 500, 800, 100, 500, 0, 1, 1, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("row%0d", i), vecs[i].exp_freq, vecs[i].exp_dir,
                  vecs[i].exp_tick, vecs[i].exp_wrap, vecs[i].exp_err);
    end

    // Reset mid-run, then restart straight into up mode
    rst = 1'b1;
    tick_clk();
    checkOutput("reset_midrun", 0, 0, 0, 0, 0);
    rst = 1'b0;
    tick_clk();
    checkOutput("restart_up", 500, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
